// File: rtl/piezo_tone_gen_if.sv
// Note-request handshake between the tune sequencer (master) and the piezo tone generator (slave).
interface piezo_tone_gen_if #(
    parameter int unsigned DUR_W = 24
);
    logic             note_vld;
    logic [15:0]      note_half_per;
    logic [DUR_W-1:0] note_dur;
    logic             note_rdy;

    modport master (
        output note_vld,
        output note_half_per,
        output note_dur,
        input  note_rdy
    );

    modport slave (
        input  note_vld,
        input  note_half_per,
        input  note_dur,
        output note_rdy
    );
endinterface

// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen: turns (half-period, duration) note requests into a 50%-duty differential square wave.
// Define TONE_GAP_EN to insert GAP_CYCLES of silence after every completed note.
module piezo_tone_gen #(
    parameter logic        FAST_SIM   = 1'b1,
    parameter int unsigned DUR_W      = 24,
    parameter int unsigned GAP_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    piezo_tone_gen_if.slave note_if,
    input  logic            stop,
    output logic            busy,
    output logic            note_done,
    output logic            piezo,
    output logic            piezo_n
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

`ifdef TONE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [DUR_W:0]   INC      = FAST_SIM ? (DUR_W+1)'(16) : (DUR_W+1)'(1);
    localparam int unsigned      GAP_LEN  = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
    localparam int unsigned      GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    logic [1:0]       state,    state_d;
    logic [15:0]      act_hp,   act_hp_d;
    logic [DUR_W-1:0] act_dur,  act_dur_d;
    logic             pend_vld, pend_vld_d;
    logic [15:0]      pend_hp,  pend_hp_d;
    logic [DUR_W-1:0] pend_dur, pend_dur_d;
    logic [15:0]      hp_cnt,   hp_cnt_d;
    logic [DUR_W-1:0] dur_cnt,  dur_cnt_d;
    logic [GAP_W-1:0] gap_cnt,  gap_cnt_d;
    logic             piezo_d;
    logic             done_d;

    logic             rdy;
    logic             accept;
    logic [DUR_W:0]   dur_sum;
    logic             note_end;
    logic             tone_wrap;
    logic             load_pend;
    logic             load_in;

    assign rdy              = ~pend_vld & ~stop;
    assign note_if.note_rdy = rdy;
    assign accept           = note_if.note_vld & rdy;

    // One extra bit so a duration near the top of the range cannot wrap past the end test.
    assign dur_sum   = {1'b0, dur_cnt} + INC;
    assign note_end  = (state == PLAY) && (dur_sum >= {1'b0, act_dur});
    assign tone_wrap = (act_hp != '0) && (hp_cnt == act_hp - 16'd1);

    always_comb begin
        state_d    = state;
        act_hp_d   = act_hp;
        act_dur_d  = act_dur;
        pend_vld_d = pend_vld;
        pend_hp_d  = pend_hp;
        pend_dur_d = pend_dur;
        hp_cnt_d   = hp_cnt;
        dur_cnt_d  = dur_cnt;
        gap_cnt_d  = gap_cnt;
        piezo_d    = piezo;
        done_d     = 1'b0;
        load_pend  = 1'b0;
        load_in    = 1'b0;

        if (stop) begin
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            hp_cnt_d   = '0;
            dur_cnt_d  = '0;
            gap_cnt_d  = '0;
            piezo_d    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_in = accept;
                end

                PLAY: begin
                    if (note_end) begin
                        done_d    = 1'b1;
                        hp_cnt_d  = '0;
                        dur_cnt_d = '0;
                        piezo_d   = 1'b0;
                        if (GAP_EN) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                            if (accept) begin
                                pend_vld_d = 1'b1;
                                pend_hp_d  = note_if.note_half_per;
                                pend_dur_d = note_if.note_dur;
                            end
                        end else if (pend_vld) begin
                            load_pend = 1'b1;
                        end else if (accept) begin
                            load_in = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dur_cnt_d = dur_sum[DUR_W-1:0];
                        if (act_hp != '0) begin
                            if (tone_wrap) begin
                                hp_cnt_d = '0;
                                piezo_d  = ~piezo;
                            end else begin
                                hp_cnt_d = hp_cnt + 16'd1;
                            end
                        end
                        if (accept) begin
                            pend_vld_d = 1'b1;
                            pend_hp_d  = note_if.note_half_per;
                            pend_dur_d = note_if.note_dur;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt_d = '0;
                        if (pend_vld) begin
                            load_pend = 1'b1;
                        end else if (accept) begin
                            load_in = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt + GAP_W'(1);
                        if (accept) begin
                            pend_vld_d = 1'b1;
                            pend_hp_d  = note_if.note_half_per;
                            pend_dur_d = note_if.note_dur;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase

            // Every note starts from a fresh phase: high on its first cycle, counters cleared.
            if (load_pend) begin
                act_hp_d   = pend_hp;
                act_dur_d  = pend_dur;
                pend_vld_d = 1'b0;
            end else if (load_in) begin
                act_hp_d  = note_if.note_half_per;
                act_dur_d = note_if.note_dur;
            end

            if (load_pend || load_in) begin
                state_d   = PLAY;
                hp_cnt_d  = '0;
                dur_cnt_d = '0;
                piezo_d   = (act_hp_d != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            act_hp    <= '0;
            act_dur   <= '0;
            pend_vld  <= 1'b0;
            pend_hp   <= '0;
            pend_dur  <= '0;
            hp_cnt    <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            piezo     <= 1'b0;
            note_done <= 1'b0;
        end else begin
            state     <= state_d;
            act_hp    <= act_hp_d;
            act_dur   <= act_dur_d;
            pend_vld  <= pend_vld_d;
            pend_hp   <= pend_hp_d;
            pend_dur  <= pend_dur_d;
            hp_cnt    <= hp_cnt_d;
            dur_cnt   <= dur_cnt_d;
            gap_cnt   <= gap_cnt_d;
            piezo     <= piezo_d;
            note_done <= done_d;
        end
    end

    assign busy    = (state != IDLE);
    assign piezo_n = ~piezo;

endmodule
